// File: rtl/shift_seq_unit_pkg.sv
// Shared definitions for the sequential shift unit: op encodings, FSM states and default widths.
// Build option SHIFT_SEQ_UNIT_FAST_EN (used by shift_seq_unit) selects single-cycle shifting.
package shift_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SHAMT_W = 5;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_seq_unit_step.sv
// Combinational shift stage: shifts by amt positions for the given op, returning data and the
// last bit shifted out (carry_prev passes through when amt is zero).
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMT_W  = DEF_SHAMT_W + 1
) (
    input  logic [1:0]        op,
    input  logic [AMT_W-1:0]  amt,
    input  logic              fill,
    input  logic              carry_prev,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry
);

    logic [DATA_W-1:0] hi_s;
    logic [DATA_W:0]   left_s;
    logic [DATA_W:0]   right_s;

    // Right shifts run on {upper fill, data, guard}; the guard slot catches the last bit out.
    always_comb begin
        case (op)
            OP_ROR:  hi_s = data;
            OP_ASR:  hi_s = {DATA_W{fill}};
            default: hi_s = {DATA_W{1'b0}};
        endcase
        left_s  = {1'b0, data} << amt;
        right_s = (DATA_W+1)'({hi_s, data, 1'b0} >> amt);
        case (op)
            OP_LSL: begin
                res_data  = left_s[DATA_W-1:0];
                res_carry = left_s[DATA_W];
            end
            default: begin
                res_data  = right_s[DATA_W:1];
                res_carry = right_s[0];
            end
        endcase
        if (amt == {AMT_W{1'b0}}) begin
            res_carry = carry_prev;
        end else begin
            res_carry = res_carry;
        end
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shift unit with valid/ready on both sides; shifts at most STEP bits per cycle.
// Define SHIFT_SEQ_UNIT_FAST_EN to finish the whole shift in one SHIFT cycle instead.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_carry,
    output logic               out_zero,
    output logic               busy
);

    localparam int CNT_W = SHAMT_W + 1;

    state_t             state_r;
    logic [1:0]         op_r;
    logic [SHAMT_W-1:0] rem_r;
    logic [DATA_W-1:0]  work_r;
    logic               fill_r;
    logic               carry_r;
    logic [CNT_W-1:0]   k_s;
    logic [DATA_W-1:0]  step_data_s;
    logic               step_carry_s;

    assign in_ready = (state_r == ST_IDLE);
    assign busy     = (state_r != ST_IDLE);

    // Positions to shift this cycle.
    always_comb begin
`ifdef SHIFT_SEQ_UNIT_FAST_EN
        k_s = {1'b0, rem_r};
`else
        if ({1'b0, rem_r} > CNT_W'(STEP)) begin
            k_s = CNT_W'(STEP);
        end else begin
            k_s = {1'b0, rem_r};
        end
`endif
    end

    shift_step #(
        .DATA_W (DATA_W),
        .AMT_W  (CNT_W)
    ) u_step (
        .op         (op_r),
        .amt        (k_s),
        .fill       (fill_r),
        .carry_prev (carry_r),
        .data       (work_r),
        .res_data   (step_data_s),
        .res_carry  (step_carry_s)
    );

    // Control FSM with working registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            op_r      <= OP_LSL;
            rem_r     <= {SHAMT_W{1'b0}};
            work_r    <= {DATA_W{1'b0}};
            fill_r    <= 1'b0;
            carry_r   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= {DATA_W{1'b0}};
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r    <= in_op;
                        rem_r   <= in_shamt;
                        work_r  <= in_data;
                        fill_r  <= in_data[DATA_W-1];
                        carry_r <= 1'b0;
                        state_r <= (in_shamt != {SHAMT_W{1'b0}}) ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    work_r  <= step_data_s;
                    carry_r <= step_carry_s;
                    rem_r   <= rem_r - k_s[SHAMT_W-1:0];
                    if (rem_r == k_s[SHAMT_W-1:0]) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes; afterwards hold until the consumer takes it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= work_r;
                        out_carry <= carry_r;
                        out_zero  <= (work_r == {DATA_W{1'b0}});
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: directed vectors against an arithmetic reference model.
module tb_shift_seq_unit;
    import shift_pkg::*;

`ifdef SHIFT_SEQ_UNIT_FAST_EN
    localparam int LAT_LSL5  = 2;
    localparam int LAT_LSR31 = 2;
`else
    localparam int LAT_LSL5  = 3;
    localparam int LAT_LSR31 = 9;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [4:0]  in_shamt;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_carry;
    logic        out_zero;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    logic        exp_active = 1'b0;
    logic [31:0] exp_data = 32'h0;
    logic        exp_carry = 1'b0;
    logic [31:0] got_data;
    logic        got_carry;
    logic        got_zero;
    int          got_lat;

    always #5 clk = ~clk;

    shift_seq_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_shamt  (in_shamt),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    // Reference result {carry, data} computed with whole-word arithmetic.
    function automatic logic [32:0] model(input logic [1:0] op, input int s, input logic [31:0] d);
        logic [31:0] r;
        logic        c;
        if (s == 0) return {1'b0, d};
        case (op)
            OP_LSL: begin r = d << s; c = d[32-s]; end
            OP_LSR: begin r = d >> s; c = d[s-1]; end
            OP_ASR: begin r = 32'($signed(d) >>> s); c = d[s-1]; end
            default: begin r = (d >> s) | (d << (32 - s)); c = r[31]; end
        endcase
        return {c, r};
    endfunction

    function automatic int model_lat(input int s);
        if (s == 0) return 1;
`ifdef SHIFT_SEQ_UNIT_FAST_EN
        return 2;
`else
        return (s + 3) / 4 + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Every cycle a result is presented, compare it with the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_active) begin
                check("out_data", out_data, exp_data);
                check("out_carry", out_carry, exp_carry);
                check("out_zero", out_zero, exp_data == 32'h0);
                check("done_in_ready", in_ready, 1'b0);
                check("done_busy", busy, 1'b1);
            end else begin
                check("spurious_valid", out_valid, 1'b0);
            end
        end
    end

    task automatic run_txn(input logic [1:0] op, input int s, input logic [31:0] d,
                           input int hold, input bit press);
        logic [32:0] m;
        m = model(op, s, d);
        exp_data   = m[31:0];
        exp_carry  = m[32];
        exp_active = 1'b1;
        check("idle_ready", in_ready, 1'b1);
        in_op    = op;
        in_shamt = 5'(s);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = ~op;
        in_shamt = ~in_shamt;
        in_data  = ~d;
        check("accept_busy", busy, 1'b1);
        got_lat = 0;
        while (out_valid !== 1'b1 && got_lat < 40) begin
            @(negedge clk);
            got_lat++;
        end
        if (out_valid !== 1'b1) begin
            check("out_valid_timeout", out_valid, 1'b1);
            exp_active = 1'b0;
            return;
        end
        check("latency", got_lat, model_lat(s));
        got_data  = out_data;
        got_carry = out_carry;
        got_zero  = out_zero;
        for (int h = 0; h < hold; h++) begin
            if (press) begin
                in_valid = 1'b1;
                in_op    = OP_LSL;
                in_shamt = 5'd0;
                in_data  = $urandom;
            end
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, got_data);
            check("hold_flags", {out_carry, out_zero}, {got_carry, got_zero});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid   = 1'b0;
        exp_active = 1'b0;
        check("release_valid", out_valid, 1'b0);
        check("release_ready", in_ready, 1'b1);
        check("release_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_op     = 2'b00;
        in_shamt  = 5'd0;
        in_data   = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_flags", {out_carry, out_zero}, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        check("model_pin_lsr31", model(OP_LSR, 31, 32'hFFFF_FFFF), 33'h1_0000_0001);
        check("model_pin_ror4", model(OP_ROR, 4, 32'h0000_000F), 33'h1_F000_0000);

        run_txn(OP_LSL, 5, 32'h0000_000A, 0, 1'b0);
        check("lsl5_data", got_data, 32'h0000_0140);
        check("lsl5_flags", {got_carry, got_zero}, 2'b00);
        check("lsl5_lat", got_lat, LAT_LSL5);

        run_txn(OP_ASR, 5, 32'h8000_0010, 0, 1'b0);
        check("asr5_data", got_data, 32'hFC00_0000);
        check("asr5_flags", {got_carry, got_zero}, 2'b10);

        run_txn(OP_LSR, 31, 32'hFFFF_FFFF, 1, 1'b0);
        check("lsr31_data", got_data, 32'h0000_0001);
        check("lsr31_carry", got_carry, 1'b1);
        check("lsr31_lat", got_lat, LAT_LSR31);

        run_txn(OP_ROR, 4, 32'h0000_000F, 0, 1'b0);
        check("ror4_data", got_data, 32'hF000_0000);
        check("ror4_carry", got_carry, 1'b1);
        check("ror4_lat", got_lat, 2);

        for (int op = 0; op < 4; op++) begin
            run_txn(2'(op), 0, 32'h0, 0, 1'b0);
            check("zero_sh_flags", {got_data, got_carry, got_zero}, {32'h0, 1'b0, 1'b1});
            check("zero_sh_lat", got_lat, 1);
        end

        run_txn(OP_LSL, 0, 32'hFFFF_FFFF, 0, 1'b0);
        run_txn(OP_LSL, 1, 32'h8000_0001, 0, 1'b0);
        run_txn(OP_ASR, 31, 32'h7FFF_FFFF, 0, 1'b0);
        run_txn(OP_ASR, 7, 32'h8765_4321, 0, 1'b0);
        run_txn(OP_LSR, 16, 32'h1234_5678, 0, 1'b0);
        run_txn(OP_ROR, 1, 32'h8000_0001, 0, 1'b0);
        run_txn(OP_ROR, 31, 32'hA5A5_0F0F, 0, 1'b0);
        run_txn(OP_LSL, 31, 32'h0000_0003, 0, 1'b0);

        // Backpressure with a competing request held on the input side.
        run_txn(OP_ROR, 12, 32'h1234_5678, 10, 1'b1);
        check("bp_data", got_data, 32'h6781_2345);

        // Asynchronous reset in the middle of a long shift.
        in_op    = OP_LSR;
        in_shamt = 5'd31;
        in_data  = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(OP_LSL, 1, 32'h0000_0001, 0, 1'b0);
        check("post_rst_data", got_data, 32'h0000_0002);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
